// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared constants for the EX-stage shift unit (shift type
//               encodings, data width, shift-amount width).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DW      = 16;
    localparam int SHAMT_W = 4;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_ROL = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/bshifter16.sv
`default_nettype none
// ============================================================================
// Module      : bshifter16
// Description : 16-bit combinational barrel shifter. Left shifts zero-fill;
//               right shifts zero-fill or sign-fill depending on arith.
// Revision    : 1.0 - initial release
// ============================================================================
module bshifter16
    import shift_pkg::*;
(
    input  logic [DW-1:0]      d,
    input  logic               right,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DW-1:0]      q
);

    logic            w_fill;
    logic [2*DW-1:0] w_ext;
    logic [2*DW-1:0] w_rsh;
    logic [DW-1:0]   w_lsh;

    assign w_fill = arith & d[DW-1];
    // Extending by a full word of fill bits lets one logical shift serve both SRL and SRA.
    assign w_ext  = {{DW{w_fill}}, d};
    assign w_rsh  = w_ext >> shamt;
    assign w_lsh  = d << shamt;

    assign q = right ? w_rsh[DW-1:0] : w_lsh;

endmodule
`default_nettype wire

// File: rtl/shift_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_ex_pipe
// Description : Two-stage pipelined EX shift unit with valid/ready handshake,
//               flush and in-flight counter. Define SHIFT_EX_ROT_EN to make
//               type 01 a rotate-left instead of a shift-left.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ex_pipe #(
    parameter int TAG_W = 4,
    parameter int DW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    input  logic [1:0]                   in_type,
    input  logic [shift_pkg::SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_zero,
    output logic [1:0]                   inflight
);
    import shift_pkg::*;

    if (DW != shift_pkg::DW) begin : g_dw_check
        $error("shift_ex_pipe: DW must be 16");
    end

    logic                 r_a_valid;
    logic [DW-1:0]        r_a_data;
    logic [1:0]           r_a_type;
    logic [SHAMT_W-1:0]   r_a_shamt;
    logic [TAG_W-1:0]     r_a_tag;

    logic                 r_b_valid;
    logic [DW-1:0]        r_out_data;
    logic [TAG_W-1:0]     r_out_tag;
    logic                 r_out_zero;
    logic [1:0]           r_inflight;

    logic                 w_b_free;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_a_nxt;
    logic                 w_b_nxt;
    logic                 w_is_right;
    logic                 w_is_arith;
    logic [DW-1:0]        w_main;
    logic [DW-1:0]        w_res;

    assign w_b_free = !r_b_valid || out_ready;
    assign in_ready = !flush && (!r_a_valid || w_b_free);
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_a_valid && w_b_free && !flush;

    // Next-state valids are shared by the valid registers and the in-flight count.
    assign w_a_nxt = flush    ? 1'b0 :
                     w_accept ? 1'b1 :
                     w_xfer   ? 1'b0 : r_a_valid;
    assign w_b_nxt = flush     ? 1'b0 :
                     w_xfer    ? 1'b1 :
                     out_ready ? 1'b0 : r_b_valid;

    assign w_is_right = r_a_type[1];
    assign w_is_arith = (r_a_type == SH_SRA);

    bshifter16 u_main (
        .d     (r_a_data),
        .right (w_is_right),
        .arith (w_is_arith),
        .shamt (r_a_shamt),
        .q     (w_main)
    );

`ifdef SHIFT_EX_ROT_EN
    logic [SHAMT_W-1:0] w_rot_amt;
    logic [DW-1:0]      w_rot_hi;

    // 16-n wraps to 0 when n=0, so the OR degenerates to d|d and passes d through.
    assign w_rot_amt = -r_a_shamt;

    bshifter16 u_rot (
        .d     (r_a_data),
        .right (1'b1),
        .arith (1'b0),
        .shamt (w_rot_amt),
        .q     (w_rot_hi)
    );

    assign w_res = (r_a_type == SH_ROL) ? (w_main | w_rot_hi) : w_main;
`else
    assign w_res = w_main;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid  <= 1'b0;
            r_a_data   <= '0;
            r_a_type   <= '0;
            r_a_shamt  <= '0;
            r_a_tag    <= '0;
            r_b_valid  <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_zero <= 1'b0;
            r_inflight <= 2'd0;
        end else begin
            r_a_valid  <= w_a_nxt;
            r_b_valid  <= w_b_nxt;
            r_inflight <= {1'b0, w_a_nxt} + {1'b0, w_b_nxt};
            if (w_accept) begin
                r_a_data  <= in_data;
                r_a_type  <= in_type;
                r_a_shamt <= in_shamt;
                r_a_tag   <= in_tag;
            end
            if (w_xfer) begin
                r_out_data <= w_res;
                r_out_tag  <= r_a_tag;
                r_out_zero <= (w_res == '0);
            end
        end
    end

    assign out_valid = r_b_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_zero  = r_out_zero;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_shift_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_ex_pipe
// Description : Self-checking bench for shift_ex_pipe: vector table plus
//               hand-written stall/flush sequences, scoreboard on the output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_ex_pipe;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [1:0]       in_type;
    logic [3:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic [1:0]       inflight;

    shift_ex_pipe #(.TAG_W(TAG_W), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_type   (in_type),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      d;
        logic [1:0]       t;
        logic [3:0]       n;
        logic [TAG_W-1:0] tag;
        logic [15:0]      exp;
    } vec_t;

    typedef struct {
        logic [15:0]      d;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] t,
                                          input logic [3:0] n);
        logic [31:0] dd;
        dd = {d, d} << n;
        case (t)
            2'b10:   return d >> n;
            2'b11:   return 16'($signed(d) >>> n);
`ifdef SHIFT_EX_ROT_EN
            2'b01:   return dd[31:16];
`else
            2'b01:   return d << n;
`endif
            default: return d << n;
        endcase
    endfunction

    // Scoreboard: the pair seen at a falling edge is what the next rising edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                q_exp.delete();
            end else if (out_valid && out_ready) begin
                exp_t e;
                n_out++;
                if (q_exp.size() == 0) begin
                    chk("unexpected output", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    e = q_exp.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_tag",  32'(out_tag),  32'(e.tag));
                    chk("out_zero", 32'(out_zero), 32'(e.d == 16'h0));
                end
            end
        end
    end

    // Entered and left at posedge+1; in_valid is left high for back-to-back use.
    task automatic send(input logic [15:0] d, input logic [1:0] t, input logic [3:0] n,
                        input logic [TAG_W-1:0] tag, input logic [15:0] exp,
                        output int stalls);
        bit ok = 0;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_type  = t;
        in_shamt = n;
        in_tag   = tag;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q_exp.push_back('{d: exp, tag: tag});
                ok = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            if (q_exp.size() == 0 && !out_valid) done = 1;
        end
        if (!done) chk("drain timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int st;
        int base;
        logic [15:0] d;
        logic [1:0]  t;
        logic [3:0]  n;

        vecs[0] = '{16'h8001, 2'b11, 4'd1,  4'd3, 16'hC000};
        vecs[1] = '{16'h0001, 2'b10, 4'd4,  4'd5, 16'h0000};
        vecs[2] = '{16'hFFFF, 2'b00, 4'd15, 4'd7, 16'h8000};
`ifdef SHIFT_EX_ROT_EN
        vecs[3] = '{16'h8001, 2'b01, 4'd1,  4'd9, 16'h0003};
`else
        vecs[3] = '{16'h8001, 2'b01, 4'd1,  4'd9, 16'h0002};
`endif
        vecs[4] = '{16'h1234, 2'b00, 4'd0,  4'd2, 16'h1234};
        vecs[5] = '{16'h8000, 2'b11, 4'd15, 4'd1, 16'hFFFF};
        vecs[6] = '{16'h7FFF, 2'b11, 4'd3,  4'd4, 16'h0FFF};
        vecs[7] = '{16'hF0F0, 2'b10, 4'd8,  4'd6, 16'h00F0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_type = '0; in_shamt = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset out_tag",   32'(out_tag),   32'd0);
        chk("reset out_zero",  32'(out_zero),  32'd0);
        chk("reset inflight",  32'(inflight),  32'd0);
        rst = 1'b0;
        #1;
        chk("reset in_ready",  32'(in_ready),  32'd1);

        // Single ops from the table, each checked for one-cycle latency and drain.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].d, vecs[i].t, vecs[i].n, vecs[i].tag, vecs[i].exp, st);
            idle();
            chk("inflight after accept", 32'(inflight), 32'd1);
            @(posedge clk);
            #1;
            chk("latency out_valid", 32'(out_valid), 32'd1);
            chk("latency out_data",  32'(out_data),  32'(vecs[i].exp));
            wait_drain();
            chk("inflight idle", 32'(inflight), 32'd0);
        end

        // Throughput: 8 back-to-back ops.
        base = n_out;
        for (int k = 0; k < 8; k++) begin
            d = 16'($urandom); t = 2'($urandom); n = 4'($urandom);
            send(d, t, n, 4'(k), model(d, t, n), st);
            chk("throughput stall", 32'(st), 32'd0);
            if (k >= 1) chk("throughput inflight", 32'(inflight), 32'd2);
        end
        idle();
        wait_drain();
        chk("throughput count", 32'(n_out - base), 32'd8);

        // Back-pressure: two accepted, third blocked, B stable, then drain.
        base = n_out;
        out_ready = 1'b0;
        send(16'h00F0, 2'b00, 4'd4, 4'hA, 16'h0F00, st);
        send(16'h8421, 2'b11, 4'd2, 4'hB, 16'hE108, st);
        in_data = 16'h4000; in_type = 2'b10; in_shamt = 4'd14; in_tag = 4'hC;
        for (int c = 0; c < 3; c++) begin
            chk("stall in_ready",  32'(in_ready),  32'd0);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall out_data",  32'(out_data),  32'h0F00);
            chk("stall out_tag",   32'(out_tag),   32'hA);
            chk("stall inflight",  32'(inflight),  32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h4000, 2'b10, 4'd14, 4'hC, 16'h0001, st);
        idle();
        wait_drain();
        chk("backpressure count", 32'(n_out - base), 32'd3);

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        send(16'h0003, 2'b00, 4'd1, 4'h1, 16'h0006, st);
        send(16'h0005, 2'b00, 4'd1, 4'h2, 16'h000A, st);
        in_data = 16'h0007; in_type = 2'b00; in_shamt = 4'd1; in_tag = 4'h3;
        flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush inflight",  32'(inflight),  32'd0);
        base = n_out;
        send(16'h0101, 2'b10, 4'd8, 4'h4, 16'h0001, st);
        idle();
        wait_drain();
        chk("post-flush count", 32'(n_out - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
